// File: rtl/bist_session_sched_if.sv
// Handshake bundle between the BIST session scheduler, the requesting cores and the shared
// BIST controller. The master side is the scheduler; the slave side is cores plus controller.
interface bist_session_sched_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0] req;
   logic            finish;
   logic            sig_ok;
   logic            bist_start;
   logic [NREQ-1:0] grant;
   logic [NREQ-1:0] done;
   logic [NREQ-1:0] pass;
   logic            busy;
   logic            timeout_err;

   modport master (
      input  req, finish, sig_ok,
      output bist_start, grant, done, pass, busy, timeout_err
   );

   modport slave (
      output req, finish, sig_ok,
      input  bist_start, grant, done, pass, busy, timeout_err
   );
endinterface

// File: rtl/bist_session_sched.sv
// Round-robin BIST session scheduler for NREQ cores sharing one BIST engine, with a session
// watchdog. Define BIST_RETRY_EN to re-run a failing first attempt once before the verdict.
module bist_session_sched #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 128,
   parameter int REL_CYC = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   bist_session_sched_if.master bus
);

   localparam int PW = $clog2(NREQ);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam int RW = $clog2(REL_CYC + 1);
   localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
   localparam logic [WW-1:0] WD_SAT   = WW'(TIMEOUT);
   localparam logic [RW-1:0] REL_LAST = RW'(REL_CYC - 1);
   localparam logic [PW-1:0] PTR_INIT = PW'(NREQ - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_SETUP,
      S_LAUNCH,
      S_WAIT,
      S_RESULT,
      S_RELEASE
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [PW-1:0] ptr;
   logic [PW-1:0] pick;
   logic [WW-1:0] wd;
   logic [RW-1:0] rel_cnt;
   logic          fin_hit;
   logic          expire;
   logic          verdict;
   logic          commit;
   logic          relaunch;

   // Nearest requester after the pointer wins: scan far-to-near so the closest overwrites.
   function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
      logic [PW-1:0] sel;
      int            idx;
      sel = p;
      for (int i = NREQ; i >= 1; i--) begin
         idx = (int'(p) + i) % NREQ;
         if (r[PW'(idx)]) sel = PW'(idx);
      end
      return sel;
   endfunction

   assign pick    = rr_pick(bus.req, ptr);
   assign verdict = fin_hit & bus.sig_ok;

   always_comb begin
      state_nxt = state;
      fin_hit   = 1'b0;
      expire    = 1'b0;
      case (state)
         S_IDLE:    if (|bus.req) state_nxt = S_ARB;
         S_ARB:     state_nxt = (|bus.req) ? S_SETUP : S_IDLE;
         S_SETUP:   state_nxt = S_LAUNCH;
         S_LAUNCH:  state_nxt = S_WAIT;
         S_WAIT: begin
            // FINISH takes precedence over a watchdog expiring in the same cycle
            if (bus.finish) begin
               fin_hit   = 1'b1;
               state_nxt = S_RESULT;
            end else if (wd == WD_LAST) begin
               expire    = 1'b1;
               state_nxt = S_RESULT;
            end
         end
         S_RESULT:  state_nxt = S_RELEASE;
         S_RELEASE: if (rel_cnt == REL_LAST) state_nxt = relaunch ? S_LAUNCH : S_ARB;
         default:   state_nxt = S_IDLE;
      endcase
   end

`ifdef BIST_RETRY_EN
   logic second;
   logic retry_pend;

   assign commit   = (fin_hit | expire) & (second | verdict);
   assign relaunch = retry_pend;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         second     <= 1'b0;
         retry_pend <= 1'b0;
      end else begin
         if (state == S_ARB)
            second <= 1'b0;
         else if (state == S_RELEASE && relaunch && rel_cnt == REL_LAST)
            second <= 1'b1;
         if (fin_hit | expire) retry_pend <= ~commit;
      end
   end
`else
   assign commit   = fin_hit | expire;
   assign relaunch = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= S_IDLE;
         ptr             <= PTR_INIT;
         wd              <= '0;
         rel_cnt         <= '0;
         bus.bist_start  <= 1'b0;
         bus.grant       <= '0;
         bus.done        <= '0;
         bus.pass        <= '0;
         bus.busy        <= 1'b0;
         bus.timeout_err <= 1'b0;
      end else begin
         state          <= state_nxt;
         bus.busy       <= (state_nxt != S_IDLE);
         bus.bist_start <= (state_nxt == S_WAIT) || (state_nxt == S_RESULT);
         bus.done       <= commit ? bus.grant : '0;

         if (state == S_ARB) begin
            if (|bus.req) begin
               bus.grant <= NREQ'(1) << pick;
               ptr       <= pick;
            end else begin
               bus.grant <= '0;
            end
         end

         if (state == S_LAUNCH)
            wd <= '0;
         else if (state == S_WAIT && wd != WD_SAT)
            wd <= wd + 1'b1;

         if (state == S_RESULT)
            rel_cnt <= '0;
         else if (state == S_RELEASE)
            rel_cnt <= rel_cnt + 1'b1;

         if (commit) begin
            bus.pass <= (bus.pass & ~bus.grant) | (verdict ? bus.grant : '0);
            if (expire) bus.timeout_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bist_session_sched.sv
// Bench for bist_session_sched: directed scenarios and randomized sessions checked against a
// session-level model of round-robin choice, verdicts, retry and the sticky timeout flag.
`timescale 1ns/1ps
module tb_bist_session_sched;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 128;
   localparam int REL_CYC = 2;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   starts = 0;
   logic start_prev = 1'b0;

   int              ref_ptr;
   logic [NREQ-1:0] ref_pass;
   logic            ref_terr;

   bist_session_sched_if #(.NREQ(NREQ)) bus ();

   bist_session_sched #(
      .NREQ    (NREQ),
      .TIMEOUT (TIMEOUT),
      .REL_CYC (REL_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.bist_start && !start_prev) starts++;
      start_prev = bus.bist_start;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
      logic [2*NREQ-1:0] dbl;
      dbl = {r, r};
      for (int k = 1; k <= NREQ; k++)
         if (dbl[p + k]) return (p + k) % NREQ;
      return 0;
   endfunction

   task automatic wait_start(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.bist_start && n < 20);
      chk("start_seen", 32'(bus.bist_start), 32'd1);
   endtask

   task automatic to_idle();
      int n;
      n = 0;
      while (bus.busy && n < 20) begin
         step();
         n++;
      end
      chk("idle_state", 32'({bus.busy, bus.bist_start, bus.grant}), 32'd0);
   endtask

   // One BIST attempt, entered at the first WAIT cycle; returns at the RESULT cycle.
   task automatic attempt(input int fin, input logic ok, output logic v, output logic ex);
      v  = 1'b0;
      ex = 1'b1;
      for (int k = 1; k <= TIMEOUT; k++) begin
         chk("wait_outputs", 32'({bus.bist_start, bus.done}), 32'({1'b1, NREQ'(0)}));
         bus.finish = (k == fin);
         bus.sig_ok = (k == fin) ? ok : 1'($urandom_range(0, 1));
         step();
         bus.finish = 1'b0;
         if (k == fin) begin
            v  = ok;
            ex = 1'b0;
            break;
         end
      end
   endtask

   task automatic session(input int exp_lat, input int fin1, input logic ok1,
                          input int fin2, input logic ok2, input logic drop_mid,
                          output int g);
      logic [NREQ-1:0] gexp;
      logic            v;
      logic            ex;
      logic            retry;
      int              n;
      g    = model_pick(bus.req, ref_ptr);
      gexp = NREQ'(1) << g;
      wait_start(n);
      if (exp_lat > 0) chk("launch_latency", n, exp_lat);
      chk("grant", 32'(bus.grant), 32'(gexp));
      if (drop_mid) bus.req[g] = 1'b0;
      attempt(fin1, ok1, v, ex);
`ifdef BIST_RETRY_EN
      retry = !v;
`else
      retry = 1'b0;
`endif
      if (retry) begin
         chk("retry_no_done", 32'(bus.done), 32'd0);
         chk("retry_pass_held", 32'(bus.pass), 32'(ref_pass));
         chk("retry_terr_held", 32'(bus.timeout_err), 32'(ref_terr));
         wait_start(n);
         chk("retry_latency", n, REL_CYC + 2);
         chk("retry_grant", 32'(bus.grant), 32'(gexp));
         attempt(fin2, ok2, v, ex);
      end
      ref_pass[g] = v;
      if (ex) ref_terr = 1'b1;
      ref_ptr = g;
      chk("done", 32'(bus.done), 32'(gexp));
      chk("pass", 32'(bus.pass), 32'(ref_pass));
      chk("timeout_err", 32'(bus.timeout_err), 32'(ref_terr));
      chk("busy_result", 32'(bus.busy), 32'd1);
      step();
      chk("release_outputs", 32'({bus.bist_start, bus.done}), 32'd0);
      chk("release_grant", 32'(bus.grant), 32'(gexp));
   endtask

   initial begin
      int              g;
      int              n;
      int              s0;
      int              f1;
      int              f2;
      logic            o1;
      logic            o2;
      logic [NREQ-1:0] nr;

      rst        = 1'b1;
      bus.req    = '0;
      bus.finish = 1'b0;
      bus.sig_ok = 1'b0;
      ref_ptr    = NREQ - 1;
      ref_pass   = '0;
      ref_terr   = 1'b0;
      repeat (3) step();
      chk("reset_outputs", 32'({bus.bist_start, bus.busy, bus.timeout_err, bus.grant, bus.done, bus.pass}), 32'd0);
      rst = 1'b0;
      step();
      chk("idle_after_reset", 32'({bus.bist_start, bus.busy, bus.grant}), 32'd0);

      // single core, passing signature
      bus.req = 4'b0001;
      session(4, 92, 1'b1, 0, 1'b0, 1'b0, g);
      bus.req = '0;
      step();
      chk("release_start_low", 32'(bus.bist_start), 32'd0);
      to_idle();

      // two held requesters alternate
      bus.req = 4'b1010;
      session(4, 92, 1'b1, 0, 1'b0, 1'b0, g);
      session(0, 40, 1'b0, 30, 1'b1, 1'b0, g);
      session(0, 100, 1'b1, 0, 1'b0, 1'b0, g);
      bus.req = '0;
      to_idle();

      // FINISH with a bad signature in the expiry cycle, then a true timeout
      bus.req = 4'b0100;
      session(4, TIMEOUT, 1'b0, TIMEOUT, 1'b0, 1'b0, g);
      session(0, 0, 1'b0, 0, 1'b0, 1'b0, g);
      bus.req = '0;
      to_idle();

      // asynchronous reset in the middle of WAIT
      bus.req = 4'b0001;
      wait_start(n);
      repeat (10) step();
      #3 rst = 1'b1;
      #1 chk("async_reset", 32'({bus.bist_start, bus.busy, bus.grant, bus.done}), 32'd0);
      step();
      chk("reset_held", 32'({bus.bist_start, bus.busy, bus.timeout_err, bus.grant, bus.done, bus.pass}), 32'd0);
      rst      = 1'b0;
      ref_ptr  = NREQ - 1;
      ref_pass = '0;
      ref_terr = 1'b0;
      session(4, 92, 1'b1, 0, 1'b0, 1'b0, g);

      // randomized sessions, stray FINISH pulses and mid-session request drops
      for (int it = 0; it < 8; it++) begin
         if (bus.req == '0) bus.req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         f1 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
         f2 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
         o1 = 1'($urandom_range(0, 1));
         o2 = 1'($urandom_range(0, 1));
         session(0, f1, o1, f2, o2, ($urandom_range(0, 2) == 0), g);
         bus.finish = 1'b1;
         bus.sig_ok = 1'($urandom_range(0, 1));
         step();
         bus.finish = 1'b0;
         chk("stray_finish", 32'({bus.done, bus.pass}), 32'({NREQ'(0), ref_pass}));
         nr    = bus.req;
         nr[g] = 1'b0;
         if ($urandom_range(0, 1) == 1) nr = nr | NREQ'($urandom_range(0, (1 << NREQ) - 1));
         bus.req = nr;
      end
      bus.req = '0;
      to_idle();

      // failing first attempt followed by a passing one
      bus.req = 4'b0001;
      s0 = starts;
      session(4, 92, 1'b0, 92, 1'b1, 1'b0, g);
      bus.req = '0;
      to_idle();
`ifdef BIST_RETRY_EN
      chk("session_starts", starts - s0, 2);
`else
      chk("session_starts", starts - s0, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
